// File: rtl/piezo_sched.sv
// +--------------------------------------------------------------------------+
// | piezo_sched : priority/alternating alarm scheduler for the piezo player  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module piezo_sched #(
  parameter int TICK_CYC  = 50000,
  parameter int NORM_GAP  = 3000,
  parameter int BATT_GAP  = 500,
  parameter int OVR_GAP   = 0,
  parameter int TMO_TICKS = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       norm_mode,
  input  logic       batt_low,
  input  logic       ovr_spd,
  input  logic       tone_done,
  output logic       tone_go,
  output logic [1:0] tone_sel,
  output logic       tone_abort
);

  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int TW = (TMO_TICKS > 0) ? $clog2(TMO_TICKS + 1) : 1;

  localparam logic [PW-1:0] C_PRESC_LAST = PW'(TICK_CYC - 1);
  localparam logic [TW-1:0] C_TMO        = TW'(TMO_TICKS);
  localparam logic [11:0]   C_NORM_GAP   = 12'(NORM_GAP);
  localparam logic [11:0]   C_BATT_GAP   = 12'(BATT_GAP);
  localparam logic [11:0]   C_OVR_GAP    = 12'(OVR_GAP);

  localparam logic [1:0] C_SEL_NONE = 2'b00;
  localparam logic [1:0] C_SEL_NORM = 2'b01;
  localparam logic [1:0] C_SEL_BATT = 2'b10;
  localparam logic [1:0] C_SEL_OVR  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [11:0]   hold_norm_q, hold_norm_d;
  logic [11:0]   hold_batt_q, hold_batt_d;
  logic [11:0]   hold_ovr_q, hold_ovr_d;
  logic          last_ovr_q, last_ovr_d;
  logic          go_q, go_d;
  logic          abort_q, abort_d;
  logic [1:0]    sel_q, sel_d;

  logic          tick;
  logic          elig_norm, elig_batt, elig_ovr;
  logic [1:0]    winner;
  logic          end_tune;

  always_comb begin
    tick    = (presc_q == C_PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;

    elig_norm = norm_mode && (hold_norm_q == 12'd0);
    elig_batt = batt_low  && (hold_batt_q == 12'd0);
    elig_ovr  = ovr_spd   && (hold_ovr_q  == 12'd0);

    // last_ovr_q set means ovr played most recently, so batt gets the next turn
    if (elig_ovr && elig_batt) winner = last_ovr_q ? C_SEL_BATT : C_SEL_OVR;
    else if (elig_ovr)         winner = C_SEL_OVR;
    else if (elig_batt)        winner = C_SEL_BATT;
    else if (elig_norm)        winner = C_SEL_NORM;
    else                       winner = C_SEL_NONE;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    go_d        = 1'b0;
    abort_d     = 1'b0;
    tmo_d       = tmo_q;
    last_ovr_d  = last_ovr_q;
    end_tune    = 1'b0;
    hold_norm_d = (tick && hold_norm_q != 12'd0) ? hold_norm_q - 12'd1 : hold_norm_q;
    hold_batt_d = (tick && hold_batt_q != 12'd0) ? hold_batt_q - 12'd1 : hold_batt_q;
    hold_ovr_d  = (tick && hold_ovr_q  != 12'd0) ? hold_ovr_q  - 12'd1 : hold_ovr_q;

    case (state_q)
      ST_IDLE: begin
        sel_d = C_SEL_NONE;
        if (winner != C_SEL_NONE) begin
          state_d = ST_PLAY;
          sel_d   = winner;
          go_d    = 1'b1;
          tmo_d   = '0;
        end
      end
      ST_PLAY: begin
        if (tick) tmo_d = tmo_q + 1'b1;
        // a done coincident with our own start pulse belongs to a previous tune
        if (tone_done && !go_q) begin
          end_tune = 1'b1;
        end else if (tmo_q >= C_TMO) begin
          end_tune = 1'b1;
          abort_d  = 1'b1;
        end
        if (end_tune) begin
          state_d = ST_IDLE;
          sel_d   = C_SEL_NONE;
          case (sel_q)
            C_SEL_NORM: hold_norm_d = C_NORM_GAP;
            C_SEL_BATT: begin
              hold_batt_d = C_BATT_GAP;
              last_ovr_d  = 1'b0;
            end
            C_SEL_OVR: begin
              hold_ovr_d = C_OVR_GAP;
              last_ovr_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = C_SEL_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      tmo_q       <= '0;
      hold_norm_q <= 12'd0;
      hold_batt_q <= 12'd0;
      hold_ovr_q  <= 12'd0;
      last_ovr_q  <= 1'b0;
      go_q        <= 1'b0;
      abort_q     <= 1'b0;
      sel_q       <= C_SEL_NONE;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tmo_q       <= tmo_d;
      hold_norm_q <= hold_norm_d;
      hold_batt_q <= hold_batt_d;
      hold_ovr_q  <= hold_ovr_d;
      last_ovr_q  <= last_ovr_d;
      go_q        <= go_d;
      abort_q     <= abort_d;
      sel_q       <= sel_d;
    end
  end

  assign tone_go    = go_q;
  assign tone_sel   = sel_q;
  assign tone_abort = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_piezo_sched.sv
// +--------------------------------------------------------------------------+
// | tb_piezo_sched : directed self-checking bench for piezo_sched            |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_piezo_sched;

  logic       clk;
  logic       rst_n;
  logic       norm_mode;
  logic       batt_low;
  logic       ovr_spd;
  logic       tone_done;
  logic       tone_go;
  logic [1:0] tone_sel;
  logic       tone_abort;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  piezo_sched #(
    .TICK_CYC (4),
    .NORM_GAP (6),
    .BATT_GAP (3),
    .OVR_GAP  (0),
    .TMO_TICKS(10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .norm_mode (norm_mode),
    .batt_low  (batt_low),
    .ovr_spd   (ovr_spd),
    .tone_done (tone_done),
    .tone_go   (tone_go),
    .tone_sel  (tone_sel),
    .tone_abort(tone_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycle k is the interval after the k-th posedge following reset release.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_go(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (tone_go === 1'b1) begin
        at = cyc;
        break;
      end
    end
    check("go_seen", 32'(at >= 0), 32'd1);
  endtask

  int g, a, t, gp, ngo;

  initial begin
    rst_n = 1'b0; norm_mode = 1'b1; batt_low = 1'b0; ovr_spd = 1'b0; tone_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_go",    32'(tone_go),    32'd0);
    check("rst_sel",   32'(tone_sel),   32'd0);
    check("rst_abort", 32'(tone_abort), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;

    // norm grant right after reset, then holdoff of 6 ticks
    step();
    check("norm_go1",  32'(tone_go),  32'd1);
    check("norm_sel1", 32'(tone_sel), 32'd1);
    step();
    check("norm_go_low", 32'(tone_go),  32'd0);
    check("norm_hold",   32'(tone_sel), 32'd1);
    while (cyc < 21) step();
    tone_done = 1'b1;
    step();
    tone_done = 1'b0;
    check("norm_done_sel", 32'(tone_sel), 32'd0);
    wait_go(40, g);
    check("norm_regrant_cyc", 32'(g),        32'd45);
    check("norm_regrant_sel", 32'(tone_sel), 32'd1);

    // done during the go cycle is ignored; request drop does not abort
    norm_mode = 1'b0;
    tone_done = 1'b1;
    step();
    check("done_on_go_ignored", 32'(tone_sel), 32'd1);
    step();
    tone_done = 1'b0;
    check("norm_end_sel", 32'(tone_sel), 32'd0);

    // ovr and batt together alternate, norm is starved
    ovr_spd = 1'b1; batt_low = 1'b1; norm_mode = 1'b1;
    wait_go(10, g);
    check("alt_sel0", 32'(tone_sel), 32'd3);
    step(); tone_done = 1'b1; step(); tone_done = 1'b0;
    wait_go(10, g);
    check("alt_sel1", 32'(tone_sel), 32'd2);
    step(); tone_done = 1'b1; step(); tone_done = 1'b0;
    wait_go(10, g);
    check("alt_sel2", 32'(tone_sel), 32'd3);
    step(); tone_done = 1'b1; step(); tone_done = 1'b0;

    // ovr alone with instant done repeats every 3 cycles
    batt_low = 1'b0; norm_mode = 1'b0;
    gp = -1;
    for (int k = 0; k < 3; k++) begin
      wait_go(10, g);
      check("ovr_rep_sel", 32'(tone_sel), 32'd3);
      if (gp >= 0) check("ovr_rep_period", 32'(g - gp), 32'd3);
      gp = g;
      step(); tone_done = 1'b1; step(); tone_done = 1'b0;
    end
    ovr_spd = 1'b0;

    // batt with no done from player -> timeout abort
    batt_low = 1'b1;
    wait_go(20, g);
    check("tmo_go_cyc", 32'(g),        32'd66);
    check("tmo_go_sel", 32'(tone_sel), 32'd2);
    a = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (tone_abort === 1'b1) begin
        a = cyc;
        break;
      end
    end
    t = g + ((3 - (g % 4) + 4) % 4);
    check("tmo_abort_cyc", 32'(a),        32'(t + 38));
    check("tmo_abort_sel", 32'(tone_sel), 32'd0);
    step();
    check("tmo_abort_pulse", 32'(tone_abort), 32'd0);
    t = a + ((3 - (a % 4) + 4) % 4) + 8;
    wait_go(30, g);
    check("tmo_regrant_cyc", 32'(g),        32'(t + 2));
    check("tmo_regrant_sel", 32'(tone_sel), 32'd2);

    // drop batt mid-play, tune still completes, no further grants
    step();
    batt_low = 1'b0;
    step(); step();
    tone_done = 1'b1;
    step();
    tone_done = 1'b0;
    check("drop_end_sel", 32'(tone_sel), 32'd0);
    ngo = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tone_go === 1'b1) ngo++;
    end
    check("drop_no_grant", 32'(ngo), 32'd0);

    // async reset in the go cycle of an ovr tune
    ovr_spd = 1'b1;
    wait_go(10, g);
    check("pre_rst_go", 32'(tone_go), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_go",  32'(tone_go),  32'd0);
    check("async_rst_sel", 32'(tone_sel), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    check("post_rst_idle", 32'(tone_go), 32'd0);
    step();
    check("post_rst_go",  32'(tone_go),  32'd1);
    check("post_rst_sel", 32'(tone_sel), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
